mem_stage_lsu: RTL and testbench

- Consumer end of the EX/MEM pipeline register: the memory-stage load/store unit.
- Reads the EX/MEM outputs and drives a req/ack data-memory port, with byte/half/word formatting.
- Stalls the upstream pipeline while an access is outstanding.
- Produces the registered MEM/WB stage: final writeback data, destination register and write enable.

---
 rtl/mem_stage_lsu.sv | 168 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: consumes EX/MEM, runs one req/ack data-memory
// access at a time with byte/half/word formatting, and produces the MEM/WB register.
module mem_stage_lsu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      func3m,
   input  logic [1:0]      result_sgnm,
   input  logic            regwr_sgnm,
   input  logic            memwr_sgnm,
   input  logic [4:0]      wr_addrm,
   input  logic [XLEN-1:0] alu_resultm,
   input  logic [XLEN-1:0] rd_final2m,
   input  logic [XLEN-1:0] pc_4m,
   input  logic [XLEN-1:0] aui_lui_resultm,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_wstrb,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic            stall_m,
   output logic            regwr_sgnw,
   output logic [4:0]      wr_addrw,
   output logic [XLEN-1:0] resultw,
   output logic            misalign_err
);

   // state | meaning
   // IDLE  | evaluate the EX/MEM instruction; non-memory ops retire in one cycle
   // BUSY  | data-memory access outstanding, dmem_* held until dmem_ack
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state;

   logic            is_load, is_store, mem_op, misalign, illegal, bad_access;
   logic [1:0]      lane;
   logic [XLEN-1:0] wb_sel_result, store_wdata, load_data;
   logic [3:0]      store_wstrb;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;

   logic            ld_q, regwr_q;
   logic [2:0]      ld_func3_q;
   logic [1:0]      ld_lane_q;
   logic [4:0]      wr_addr_q;

   assign lane     = alu_resultm[1:0];
   assign is_store = memwr_sgnm;
   assign is_load  = !memwr_sgnm && (result_sgnm == 2'b01);
   assign mem_op   = memwr_sgnm | (result_sgnm == 2'b01);

   always_comb begin
      illegal  = 1'b0;
      misalign = 1'b0;
      if (is_store)
         illegal = func3m[2] || (func3m[1:0] == 2'b11);
      else
         illegal = (func3m == 3'b011) || (func3m == 3'b110) || (func3m == 3'b111);
      case (func3m[1:0])
         2'b01:   misalign = lane[0];
         2'b10:   misalign = (lane != 2'b00);
         default: misalign = 1'b0;
      endcase
   end

   assign bad_access = misalign | illegal;

   always_comb begin
      store_wdata = rd_final2m;
      store_wstrb = 4'b1111;
      case (func3m[1:0])
         2'b00: begin
            store_wdata = {4{rd_final2m[7:0]}};
            store_wstrb = 4'b0001 << lane;
         end
         2'b01: begin
            store_wdata = {2{rd_final2m[15:0]}};
            store_wstrb = 4'b0011 << lane;
         end
         default: begin
            store_wdata = rd_final2m;
            store_wstrb = 4'b1111;
         end
      endcase
   end

   always_comb begin
      wb_sel_result = alu_resultm;
      case (result_sgnm)
         2'b10:   wb_sel_result = pc_4m;
         2'b11:   wb_sel_result = aui_lui_resultm;
         default: wb_sel_result = alu_resultm;
      endcase
   end

   // Lane and func3 come from the values captured at request time.
   always_comb begin
      ld_byte   = dmem_rdata[{ld_lane_q, 3'b000} +: 8];
      ld_half   = ld_lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      load_data = dmem_rdata;
      case (ld_func3_q)
         3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
         default: load_data = dmem_rdata;
      endcase
   end

   assign stall_m = (state == IDLE) ? (mem_op && !bad_access) : !dmem_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         dmem_wstrb   <= 4'b0000;
         regwr_sgnw   <= 1'b0;
         wr_addrw     <= 5'd0;
         resultw      <= '0;
         misalign_err <= 1'b0;
         ld_q         <= 1'b0;
         regwr_q      <= 1'b0;
         ld_func3_q   <= 3'b000;
         ld_lane_q    <= 2'b00;
         wr_addr_q    <= 5'd0;
      end else begin
         misalign_err <= 1'b0;
         if (state == IDLE) begin
            if (mem_op && bad_access) begin
               misalign_err <= 1'b1;
               regwr_sgnw   <= 1'b0;
            end else if (mem_op) begin
               state      <= BUSY;
               dmem_req   <= 1'b1;
               dmem_we    <= is_store;
               dmem_addr  <= {alu_resultm[XLEN-1:2], 2'b00};
               dmem_wdata <= is_store ? store_wdata : '0;
               dmem_wstrb <= is_store ? store_wstrb : 4'b0000;
               ld_q       <= is_load;
               ld_func3_q <= func3m;
               ld_lane_q  <= lane;
               regwr_q    <= regwr_sgnm;
               wr_addr_q  <= wr_addrm;
               regwr_sgnw <= 1'b0;
            end else begin
               regwr_sgnw <= regwr_sgnm;
               wr_addrw   <= wr_addrm;
               resultw    <= wb_sel_result;
            end
         end else if (dmem_ack) begin
            // EX/MEM is still held on the ack cycle, so the non-load mux is live.
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 4'b0000;
            regwr_sgnw <= regwr_q;
            wr_addrw   <= wr_addr_q;
            resultw    <= ld_q ? load_data : wb_sel_result;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed cases then random instruction stream
// against a byte-addressed memory model and a separate word-based memory responder.
module tb_mem_stage_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  func3m;
   logic [1:0]  result_sgnm;
   logic        regwr_sgnm, memwr_sgnm;
   logic [4:0]  wr_addrm;
   logic [31:0] alu_resultm, rd_final2m, pc_4m, aui_lui_resultm;
   logic        dmem_req, dmem_we, dmem_ack, stall_m, regwr_sgnw, misalign_err;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, resultw;
   logic [3:0]  dmem_wstrb;
   logic [4:0]  wr_addrw;

   always #5 clk = ~clk;

   mem_stage_lsu #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .func3m(func3m), .result_sgnm(result_sgnm),
      .regwr_sgnm(regwr_sgnm), .memwr_sgnm(memwr_sgnm), .wr_addrm(wr_addrm),
      .alu_resultm(alu_resultm), .rd_final2m(rd_final2m), .pc_4m(pc_4m),
      .aui_lui_resultm(aui_lui_resultm), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_m(stall_m),
      .regwr_sgnw(regwr_sgnw), .wr_addrw(wr_addrw), .resultw(resultw),
      .misalign_err(misalign_err)
   );

   // kind: 0 = WB write, 1 = misalign pulse, 2 = memory request
   typedef struct packed {
      logic [1:0]  kind;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [7:0]  reqlen;
      logic        chk_wdata;
      logic [4:0]  wr;
      logic [31:0] res;
   } ev_t;

   ev_t         expq[$];
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  mem_b [0:63];
   logic [31:0] mem_w [0:15];
   int          cur_delay = 0;
   bit          resp_en = 1'b0;
   logic        resp_ack = 1'b0;
   logic        manual_ack = 1'b0;
   bit          abort_run = 1'b0;

   assign dmem_ack = resp_ack | manual_ack;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic poke_word(input logic [31:0] a, input logic [31:0] v);
      mem_w[a[5:2]] = v;
      for (int i = 0; i < 4; i++) mem_b[int'(a[5:2]) * 4 + i] = v[8*i +: 8];
   endtask

   task automatic drive_nop();
      func3m = 3'b000; result_sgnm = 2'b00; regwr_sgnm = 1'b0; memwr_sgnm = 1'b0;
      wr_addrm = 5'd0; alu_resultm = '0; rd_final2m = '0; pc_4m = '0; aui_lui_resultm = '0;
   endtask

   // Memory responder: acks d cycles after it first sees a request.
   initial begin
      int cnt;
      cnt = -1;
      dmem_rdata = '0;
      forever begin
         @(negedge clk);
         resp_ack   = 1'b0;
         dmem_rdata = $urandom;
         if (rst || !resp_en || !dmem_req) begin
            cnt = -1;
         end else begin
            if (cnt < 0) cnt = cur_delay;
            if (cnt == 0) begin
               resp_ack = 1'b1;
               cnt = -1;
               if (dmem_we) begin
                  for (int i = 0; i < 4; i++)
                     if (dmem_wstrb[i]) mem_w[dmem_addr[5:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
               end else begin
                  dmem_rdata = mem_w[dmem_addr[5:2]];
               end
            end else begin
               cnt--;
            end
         end
      end
   end

   always @(posedge clk) if (rst) abort_run = 1'b1;

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   initial begin
      bit   prev_req;
      int   run_len;
      ev_t  cur, e;
      logic s_we;
      logic [31:0] s_addr, s_wdata;
      logic [3:0]  s_wstrb;
      prev_req = 1'b0; run_len = 0; cur = '0;
      s_we = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
      forever begin
         @(negedge clk);
         if (dmem_req === 1'b1) begin
            if (!prev_req) begin
               run_len = 1;
               if (expq.size() == 0 || expq[0].kind != 2'd2) begin
                  checks++; errors++;
                  $display("FAIL unexpected_req: got addr 0x%08h, no request expected", dmem_addr);
               end else begin
                  cur = expq.pop_front();
                  chk("req_we", dmem_we, cur.we);
                  chk("req_addr", dmem_addr, cur.addr);
                  chk("req_wstrb", dmem_wstrb, cur.wstrb);
                  if (cur.chk_wdata) chk("req_wdata", dmem_wdata, cur.wdata);
               end
               s_we = dmem_we; s_addr = dmem_addr; s_wdata = dmem_wdata; s_wstrb = dmem_wstrb;
            end else begin
               run_len++;
               checks++;
               if (dmem_we !== s_we || dmem_addr !== s_addr || dmem_wdata !== s_wdata ||
                   dmem_wstrb !== s_wstrb) begin
                  errors++;
                  $display("FAIL req_hold: got addr 0x%08h wdata 0x%08h expected addr 0x%08h wdata 0x%08h",
                           dmem_addr, dmem_wdata, s_addr, s_wdata);
               end
            end
         end else if (prev_req) begin
            if (!abort_run && cur.reqlen != 0) chk("req_len", run_len, 32'(cur.reqlen));
         end
         if (dmem_req !== 1'b1) abort_run = 1'b0;
         prev_req = (dmem_req === 1'b1);
         if (misalign_err === 1'b1) begin
            if (expq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_misalign: got pulse, none expected");
            end else begin
               e = expq.pop_front();
               chk("misalign_event", 32'(e.kind), 32'd1);
            end
         end
         if (regwr_sgnw === 1'b1) begin
            if (expq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_wb: got wr_addrw %0d resultw 0x%08h, none expected", wr_addrw, resultw);
            end else begin
               e = expq.pop_front();
               chk("wb_event", 32'(e.kind), 32'd0);
               chk("wb_addr", wr_addrw, e.wr);
               chk("wb_data", resultw, e.res);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge where the next instruction may issue.
   task automatic issue(input logic [2:0] f3, input logic [1:0] sel, input logic rw,
                        input logic mw, input logic [4:0] wa, input logic [31:0] alu,
                        input logic [31:0] sd, input int d);
      ev_t e;
      int nb, lane, base, stalls;
      bit mem, load, bad, done, s;
      logic [31:0] v, pc4, aui;
      pc4  = $urandom;
      aui  = $urandom;
      e    = '0;
      load = !mw && (sel == 2'b01);
      mem  = mw || (sel == 2'b01);
      nb   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if (mw) bad = (f3 > 3'd2);
      else    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      bad  = bad || ((int'(alu[1:0]) % nb) != 0);
      lane = int'(alu[1:0]);
      base = int'(alu[5:2]) * 4;
      if (mem && bad) begin
         e.kind = 2'd1;
         expq.push_back(e);
      end else if (mem) begin
         e.kind = 2'd2; e.we = mw; e.addr = alu & ~32'h3; e.reqlen = 8'(d + 1); e.chk_wdata = mw;
         if (mw) begin
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
            for (int i = 0; i < nb; i++) begin
               e.wstrb[lane + i] = 1'b1;
               mem_b[base + lane + i] = sd[8*i +: 8];
            end
            expq.push_back(e);
         end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_b[base + lane + i];
            if (!f3[2] && nb < 4 && v[8*nb - 1])
               for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            expq.push_back(e);
            if (rw) begin
               e = '0; e.kind = 2'd0; e.wr = wa; e.res = v;
               expq.push_back(e);
            end
         end
      end else if (rw) begin
         e.kind = 2'd0; e.wr = wa;
         e.res = (sel == 2'b10) ? pc4 : (sel == 2'b11) ? aui : alu;
         expq.push_back(e);
      end
      func3m = f3; result_sgnm = sel; regwr_sgnm = rw; memwr_sgnm = mw; wr_addrm = wa;
      alu_resultm = alu; rd_final2m = sd; pc_4m = pc4; aui_lui_resultm = aui;
      cur_delay = d;
      stalls = 0; done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         s = (stall_m === 1'b1);
         if (s) stalls++;
         @(negedge clk);
         if (!s) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL stall_timeout: got stall_m stuck high, required release within 40 cycles");
      end
      chk("stall_cycles", stalls, (mem && !bad) ? d + 1 : 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ev_t e;
      logic [2:0]  f3;
      logic [1:0]  sel;
      logic [31:0] a;
      int          k;
      for (int i = 0; i < 16; i++) poke_word(32'(i * 4), $urandom);
      rst = 1'b1;
      drive_nop();
      repeat (2) @(negedge clk);
      chk("rst_req", dmem_req, 1'b0);
      chk("rst_we", dmem_we, 1'b0);
      chk("rst_wstrb", dmem_wstrb, 4'b0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      chk("rst_regwr", regwr_sgnw, 1'b0);
      chk("rst_wr_addr", wr_addrw, 5'd0);
      chk("rst_result", resultw, 32'h0);
      chk("rst_misalign", misalign_err, 1'b0);
      rst = 1'b0;
      resp_en = 1'b1;

      issue(3'b010, 2'b00, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 0);
      issue(3'b000, 2'b00, 1'b0, 1'b1, 5'd0, 32'h103, 32'hAABBCCDD, 2);
      poke_word(32'h200, 32'h00F00000);
      issue(3'b000, 2'b01, 1'b1, 1'b0, 5'd6, 32'h202, 32'h0, 0);
      issue(3'b100, 2'b01, 1'b1, 1'b0, 5'd7, 32'h202, 32'h0, 0);
      issue(3'b010, 2'b01, 1'b1, 1'b0, 5'd8, 32'h301, 32'h0, 0);

      // Reset lands while the access is outstanding; the late ack must be ignored.
      resp_en = 1'b0;
      func3m = 3'b010; result_sgnm = 2'b01; regwr_sgnm = 1'b1; memwr_sgnm = 1'b0;
      wr_addrm = 5'd7; alu_resultm = 32'h40;
      e = '0; e.kind = 2'd2; e.addr = 32'h40;
      expq.push_back(e);
      @(negedge clk);
      @(negedge clk);
      chk("busy_req", dmem_req, 1'b1);
      rst = 1'b1;
      drive_nop();
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy_req", dmem_req, 1'b0);
      chk("rst_busy_stall", stall_m, 1'b0);
      chk("rst_busy_regwr", regwr_sgnw, 1'b0);
      @(negedge clk);
      manual_ack = 1'b1;
      #1 chk("idle_ack_stall", stall_m, 1'b0);
      @(negedge clk);
      manual_ack = 1'b0;
      chk("late_ack_req", dmem_req, 1'b0);
      chk("late_ack_regwr", regwr_sgnw, 1'b0);
      chk("late_ack_wr_addr", wr_addrw, 5'd0);
      chk("late_ack_result", resultw, 32'h0);
      resp_en = 1'b1;

      poke_word(32'h0, 32'h80000000);
      issue(3'b001, 2'b01, 1'b1, 1'b0, 5'd9, 32'h2, 32'h0, 0);
      issue(3'b010, 2'b00, 1'b0, 1'b1, 5'd0, 32'h10, 32'h12345678, 1);

      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 3);
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         f3 = 3'($urandom_range(0, 7));
         case (k)
            0: begin
               sel = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(2, 3));
               issue(f3, sel, 1'b1, 1'b0, 5'($urandom), a, $urandom, 0);
            end
            1: issue(f3, 2'b01, 1'($urandom), 1'b0, 5'($urandom), a, $urandom,
                     $urandom_range(0, 3));
            2: begin
               if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
               issue(f3, 2'($urandom), 1'b0, 1'b1, 5'($urandom), a, $urandom,
                     $urandom_range(0, 3));
            end
            default: begin
               sel = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(2, 3));
               issue(f3, sel, 1'($urandom), 1'b0, 5'($urandom), a, $urandom, 0);
            end
         endcase
      end

      drive_nop();
      repeat (5) @(negedge clk);
      chk("queue_empty", expq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
